// File: rtl/health_round_ctrl.sv
// -----------------------------------------------------------------------------
// health_round_ctrl
//
// Owns both players' health and sequences one round of play:
//   IDLE -> FIGHT -> DRAIN -> KO_HOLD -> IDLE
//
// Damage arrives per side over a req/ack handshake. A request is consumed
// (acked) in every state, but damage is applied only in FIGHT and only while
// that side's invulnerability cooldown has expired. Once either side reaches
// zero the round drains: the controller waits for the status bar's animated
// health to catch up with the authoritative value before raising KO, holds the
// KO for a fixed time, then returns to IDLE. ko and winner persist in IDLE
// until the next round starts.
//
// Ports
//   clk             in   1  system clock
//   reset           in   1  asynchronous, active-high reset
//   round_start     in   1  level, sampled only in IDLE
//   hit_req_l/_r    in   1  damage request, held until the matching ack
//   dmg_l/_r        in   5  damage amount, stable while the request is high
//   final_health_l  in   5  animated left health from the status bar
//   final_health_r  in   5  animated right health from the status bar
//   curr_health_l   out  5  authoritative left health
//   curr_health_r   out  5  authoritative right health
//   hit_ack_l/_r    out  1  1-cycle pulse: request consumed
//   hit_applied_l/_r out 1  1-cycle pulse with ack when damage was applied
//   round_active    out  1  high only in FIGHT
//   ko              out  1  high from KO_HOLD entry until FIGHT is next entered
//   winner          out  2  00 none, 01 left wins, 10 right wins, 11 draw
// -----------------------------------------------------------------------------
module health_round_ctrl #(
  parameter int MAX_HEALTH      = 20,
  parameter int COOLDOWN_CYCLES = 25_000_000,
  parameter int KO_HOLD_CYCLES  = 150_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       round_start,
  input  logic       hit_req_l,
  input  logic [4:0] dmg_l,
  input  logic       hit_req_r,
  input  logic [4:0] dmg_r,
  input  logic [4:0] final_health_l,
  input  logic [4:0] final_health_r,
  output logic [4:0] curr_health_l,
  output logic [4:0] curr_health_r,
  output logic       hit_ack_l,
  output logic       hit_ack_r,
  output logic       hit_applied_l,
  output logic       hit_applied_r,
  output logic       round_active,
  output logic       ko,
  output logic [1:0] winner
);

  // Counter widths are sized from the parameters so a 150M-cycle hold and a
  // 100-cycle test hold both synthesize to the minimum register count.
  localparam int CD_W = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
  localparam int KO_W = (KO_HOLD_CYCLES > 1) ? $clog2(KO_HOLD_CYCLES) : 1;

  localparam logic [CD_W-1:0] CD_LOAD     = CD_W'(COOLDOWN_CYCLES);
  // The hold counter counts down to zero inclusive, so it is loaded with
  // N-1 to spend exactly N cycles in KO_HOLD. A zero hold behaves as one.
  localparam logic [KO_W-1:0] KO_LOAD     = (KO_HOLD_CYCLES > 0) ?
                                            KO_W'(KO_HOLD_CYCLES - 1) : '0;
  localparam logic [4:0]      HEALTH_INIT = 5'(MAX_HEALTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FIGHT   = 2'd1,
    S_DRAIN   = 2'd2,
    S_KO_HOLD = 2'd3
  } state_t;

  // Index 0 is the left player, index 1 the right player, so both sides share
  // one description of the handshake and damage path.
  localparam int L = 0;
  localparam int R = 1;

  state_t               state, state_next;
  logic [1:0][4:0]      health, health_next;
  logic [1:0][CD_W-1:0] cooldown, cooldown_next;
  logic [1:0]           ack, ack_next;
  logic [1:0]           applied, applied_next;
  logic [KO_W-1:0]      hold_cnt, hold_cnt_next;
  logic                 round_active_next;
  logic                 ko_next;
  logic [1:0]           winner_next;

  logic [1:0]           req;
  logic [1:0][4:0]      dmg;
  logic [1:0][4:0]      final_health;

  assign req          = {hit_req_r, hit_req_l};
  assign dmg          = {dmg_r, dmg_l};
  assign final_health = {final_health_r, final_health_l};

  function automatic logic [4:0] sat_sub(input logic [4:0] h, input logic [4:0] d);
    return (h > d) ? (h - d) : 5'd0;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_next    = state;
    health_next   = health;
    ack_next      = '0;
    applied_next  = '0;
    hold_cnt_next = hold_cnt;
    ko_next       = ko;
    winner_next   = winner;

    for (int i = 0; i < 2; i++) begin
      cooldown_next[i] = (cooldown[i] != '0) ? cooldown[i] - 1'b1 : cooldown[i];

      // A request is sampled only while no ack is outstanding; a request
      // still held during its ack cycle is not seen again until ack falls.
      if (req[i] && !ack[i]) begin
        ack_next[i] = 1'b1;
        if (state == S_FIGHT && cooldown[i] == '0) begin
          health_next[i]   = sat_sub(health[i], dmg[i]);
          cooldown_next[i] = CD_LOAD;
          applied_next[i]  = 1'b1;
        end
      end
    end

    unique case (state)
      S_IDLE: begin
        if (round_start) begin
          state_next    = S_FIGHT;
          health_next   = {HEALTH_INIT, HEALTH_INIT};
          cooldown_next = '0;
          ko_next       = 1'b0;
          winner_next   = 2'b00;
        end
      end

      S_FIGHT: begin
        // Evaluated on the registered health, i.e. the edge after the update
        // that emptied a bar. Bit 1 flags left empty (right wins), bit 0
        // flags right empty (left wins); both set is a draw.
        if (health[L] == 5'd0 || health[R] == 5'd0) begin
          state_next  = S_DRAIN;
          winner_next = {health[L] == 5'd0, health[R] == 5'd0};
        end
      end

      S_DRAIN: begin
        if (final_health[L] == health[L] && final_health[R] == health[R]) begin
          state_next    = S_KO_HOLD;
          ko_next       = 1'b1;
          hold_cnt_next = KO_LOAD;
        end
      end

      S_KO_HOLD: begin
        if (hold_cnt == '0) state_next    = S_IDLE;
        else                hold_cnt_next = hold_cnt - 1'b1;
      end

      default: state_next = S_IDLE;
    endcase

    round_active_next = (state_next == S_FIGHT);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      health       <= {HEALTH_INIT, HEALTH_INIT};
      cooldown     <= '0;
      ack          <= '0;
      applied      <= '0;
      hold_cnt     <= '0;
      round_active <= 1'b0;
      ko           <= 1'b0;
      winner       <= 2'b00;
    end else begin
      state        <= state_next;
      health       <= health_next;
      cooldown     <= cooldown_next;
      ack          <= ack_next;
      applied      <= applied_next;
      hold_cnt     <= hold_cnt_next;
      round_active <= round_active_next;
      ko           <= ko_next;
      winner       <= winner_next;
    end
  end

  assign curr_health_l = health[L];
  assign curr_health_r = health[R];
  assign hit_ack_l     = ack[L];
  assign hit_ack_r     = ack[R];
  assign hit_applied_l = applied[L];
  assign hit_applied_r = applied[R];

endmodule
